// File: rtl/ssd_pkg.sv
// Shared constants and helpers for the seven-segment scan controller.
// Segment patterns are active-low: bit6=a ... bit0=g.
package ssd_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h7E;
    localparam logic [3:0] AN_OFF    = 4'hF;

    // 0 = left-most digit (digit4) ... 3 = right-most digit (digit1)
    typedef logic [1:0] digit_idx_t;

    function automatic logic [3:0] an_decode(input digit_idx_t idx);
        return ~(4'b1000 >> idx);
    endfunction

endpackage

// File: rtl/ssd_scan_ctrl_tick_gen.sv
// Digit-slot prescaler: counts 0..CLK_DIV-1, flags the wrap cycle and
// the dead-time cycle (cnt == 0).
module tick_gen #(
    parameter int CLK_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic slot_tick,
    output logic dead
);

    localparam int W = $clog2(CLK_DIV);
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        slot_tick = (cnt == LAST);
        dead      = (cnt == '0);
    end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Time-multiplexed scan of four seven-segment digits over one shared
// cathode bus, with per-digit blank/blink and frame-aligned pattern updates.
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int CLK_DIV      = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] digit4,
    input  logic [6:0] digit3,
    input  logic [6:0] digit2,
    input  logic [6:0] digit1,
    input  logic       load,
    input  logic [3:0] blank_mask,
    input  logic [3:0] blink_mask,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       frame_done
);

    localparam int BW = $clog2(BLINK_FRAMES) + 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic          slot_tick;
    logic          dead;
    logic          boundary;
    digit_idx_t    idx;
    logic [BW-1:0] blink_cnt;
    logic          phase;

    logic [6:0] in_dig     [4];
    logic [6:0] shadow     [4];
    logic [6:0] pend       [4];
    logic [3:0] shadow_blank, shadow_blink;
    logic [3:0] pend_blank, pend_blink;
    logic       pending;

    logic       dark;
    logic [6:0] cur_pat;

    tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
        .clk       (clk),
        .rst       (rst),
        .slot_tick (slot_tick),
        .dead      (dead)
    );

    always_comb begin
        in_dig[0] = digit4;
        in_dig[1] = digit3;
        in_dig[2] = digit2;
        in_dig[3] = digit1;
        boundary  = slot_tick && (idx == 2'd3);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else begin
            if (slot_tick) begin
                idx <= idx + 1'b1;
            end
            if (boundary) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt <= '0;
                    phase     <= ~phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

    // A load in the boundary cycle bypasses the pending stage entirely.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 4; i++) begin
                shadow[i] <= SEG_BLANK;
                pend[i]   <= SEG_BLANK;
            end
            shadow_blank <= '0;
            shadow_blink <= '0;
            pend_blank   <= '0;
            pend_blink   <= '0;
            pending      <= 1'b0;
        end else if (boundary) begin
            if (load) begin
                for (int unsigned i = 0; i < 4; i++) shadow[i] <= in_dig[i];
                shadow_blank <= blank_mask;
                shadow_blink <= blink_mask;
            end else if (pending) begin
                for (int unsigned i = 0; i < 4; i++) shadow[i] <= pend[i];
                shadow_blank <= pend_blank;
                shadow_blink <= pend_blink;
            end
            pending <= 1'b0;
        end else if (load) begin
            for (int unsigned i = 0; i < 4; i++) pend[i] <= in_dig[i];
            pend_blank <= blank_mask;
            pend_blink <= blink_mask;
            pending    <= 1'b1;
        end
    end

    always_comb begin
        cur_pat = shadow[idx];
        dark    = dead || shadow_blank[2'd3 - idx]
                       || (shadow_blink[2'd3 - idx] && phase);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg        <= SEG_BLANK;
            an         <= AN_OFF;
            frame_done <= 1'b0;
        end else begin
            seg        <= dark ? SEG_BLANK : cur_pat;
            an         <= dark ? AN_OFF : an_decode(idx);
            frame_done <= boundary;
        end
    end

endmodule

// File: doc/ssd_scan_ctrl.md
Name: ssd_scan_ctrl

Overview:
Time-multiplexing scheduler for the board's single shared seven-segment cathode bus.
- Takes the four per-digit patterns produced by the control FSMs (digit4 = left-most) and drives them one digit at a time.
- Drives the shared segment lines plus four active-low anode enables.
- Provides per-digit blanking and blinking, used for the LOCK/WARNING indications.
- Tear-free: new patterns are applied only at frame boundaries.

Parameters:
CLK_DIV, 50000, clk cycles per digit slot (>=2); slot cycle 0 is anode dead time.
BLINK_FRAMES, 64, frames per blink half-period (>=1).

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
digit4  in  7  pattern, left-most digit, active-low segments, bit6=a … bit0=g
digit3  in  7  pattern, digit 3
digit2  in  7  pattern, digit 2
digit1  in  7  pattern, right-most digit
load  in  1  request to adopt digit4..1, blank_mask, blink_mask
blank_mask  in  4  bit3=digit4 … bit0=digit1; 1 = digit dark
blink_mask  in  4  same bit order; 1 = digit blinks
seg  out  7  shared cathode bus, active-low
an  out  4  anode enables, active-low, an[3]=digit4
frame_done  out  1  one-cycle pulse at end of each 4-slot frame

Behaviour:
Reset (rst high at a clk edge):
- cnt=0, idx=0, blink_cnt=0, phase=0, pending=0.
- Shadow patterns = 7'h7F; shadow masks = 0.
- seg=7'h7F, an=4'hF, frame_done=0.
- Reset mid-frame aborts the scan immediately; any pending load is discarded.

Scan counters:
- cnt counts 0..CLK_DIV-1, then wraps to 0.
- On wrap, idx advances 0->1->2->3->0.
- idx mapping: 0=digit4, 1=digit3, 2=digit2, 3=digit1.

Outputs:
- All outputs are registered: values in cycle n reflect (cnt, idx, shadow, phase) of cycle n-1.
- When cnt==0 (dead time): an=4'hF, seg=7'h7F.
- Otherwise the selected digit is visible, i.e. an has a single 0 at bit (3-idx) and seg = shadow[idx].
- Exception: if shadow blank bit is set, or (blink bit set and phase==1), then an=4'hF and seg=7'h7F for the whole slot.

Frame boundary:
- Boundary = the cycle with idx==3 and cnt==CLK_DIV-1.
- frame_done is registered, so it is high in the following cycle.

Load:
- load==1 captures the inputs into the pending registers and sets pending.
- Multiple loads within a frame: the last one wins.
- At the boundary, if pending: shadow <= pending, then pending is cleared.
- load in the boundary cycle itself: that cycle's inputs go straight to shadow and pending ends cleared.

Blink:
- blink_cnt increments at each boundary.
- When blink_cnt reaches BLINK_FRAMES-1, blink_cnt wraps to 0 and phase toggles.
- A shadow update does not reset phase.

Width rules:
- cnt width = clog2(CLK_DIV); blink_cnt width = clog2(BLINK_FRAMES)+1.
- No arithmetic overflow is permitted; counters wrap only by compare.

Decomposition:
- Package ssd_pkg holds:
  - SEG_BLANK=7'h7F, SEG_DASH=7'h7E, AN_OFF=4'hF
  - a 2-bit digit-index type
  - an idx-to-anode decode function
- Sub-module: tick_gen. It is the parameterised prescaler (cnt) producing slot_tick on wrap and the dead-time flag cnt==0.
- Index, blink logic, shadow registers and output registers stay in ssd_scan_ctrl.

Test Plan (CLK_DIV=4, BLINK_FRAMES=2):
1. Reset, then load digits 0x01,0x4F,0x12,0x06 at the first boundary.
   - Expect per slot: one dead cycle (an=F, seg=7F), then 3 cycles of the digit.
   - Anode order: an=0111 seg=01, then 1011/4F, 1101/12, 1110/06.
   - frame_done pulses once every 16 cycles.
2. load pulsed mid-frame (during idx=1) with new digit1=0x24.
   - Current frame still shows the old digit1 0x06.
   - The next frame shows 0x24.
   - A second load later in the same frame overrides the first.
3. blank_mask=4'b1000 loaded.
   - The digit4 slot is an=F, seg=7F for all 4 cycles.
   - The other slots are unchanged; frame length is still 16 cycles.
4. blink_mask=4'b0001.
   - digit1 is visible for 2 frames, dark for 2 frames, visible again.
   - phase toggles every 2 frame_done pulses.
5. rst asserted in a mid-slot cycle while a load is pending.
   - The next cycle shows seg=7F, an=F, frame_done=0.
   - After release, the display stays blank until a new load reaches a boundary.
6. load asserted exactly in the boundary cycle.
   - The next frame's first visible slot shows the new digit4.
   - pending is 0 afterwards, so there is no double update at the following boundary.
